// File: rtl/data_ram_pkg.sv
// Shared types and helpers for the dual-port data RAM: init sequencer states
// and the address window check used by both request ports.
package data_ram_pkg;

  typedef enum logic {
    INIT,
    READY
  } init_state_e;

  localparam int MaxReadLatency = 2;

  // Subtraction is only meaningful once addr >= base, hence the short-circuit.
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [32:0] bytes);
    return (addr >= base) && ({1'b0, addr - base} < bytes);
  endfunction

endpackage

// File: rtl/dp_data_ram_resp_pipe.sv
// Per-port response pipeline: shifts {valid, err} ReadLatency deep and, for
// two-cycle latency, registers the (error-masked) read word once more.
module dp_data_ram_resp_pipe
  import data_ram_pkg::*;
#(
  parameter int DataWidth   = 32,
  parameter int ReadLatency = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic                 err_i,
  input  logic [DataWidth-1:0] rdata_i,
  output logic                 rvalid_o,
  output logic                 err_o,
  output logic [DataWidth-1:0] rdata_o
);

  logic                 valid1_reg;
  logic                 err1_reg;
  logic [DataWidth-1:0] rdata1_masked;

  // err only follows accepted requests so it holds between responses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid1_reg <= 1'b0;
      err1_reg   <= 1'b0;
    end else begin
      valid1_reg <= valid_i;
      if (valid_i) err1_reg <= err_i;
    end
  end

  assign rdata1_masked = err1_reg ? '0 : rdata_i;

  if (ReadLatency >= MaxReadLatency) begin : g_two_stage
    logic                 valid2_reg;
    logic                 err2_reg;
    logic [DataWidth-1:0] rdata2_reg;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid2_reg <= 1'b0;
        err2_reg   <= 1'b0;
        rdata2_reg <= '0;
      end else begin
        valid2_reg <= valid1_reg;
        if (valid1_reg) begin
          err2_reg   <= err1_reg;
          rdata2_reg <= rdata1_masked;
        end
      end
    end

    assign rvalid_o = valid2_reg;
    assign err_o    = err2_reg;
    assign rdata_o  = rdata2_reg;
  end else begin : g_one_stage
    assign rvalid_o = valid1_reg;
    assign err_o    = err1_reg;
    assign rdata_o  = rdata1_masked;
  end

endmodule

// File: rtl/dp_data_ram.sv
// True dual-port data RAM with byte enables, read-first behaviour, port-A byte
// priority on colliding writes, range errors and a post-reset zeroing pass.
module dp_data_ram
  import data_ram_pkg::*;
#(
  parameter int          Depth       = 1024,
  parameter int          DataWidth   = 32,
  parameter logic [31:0] BaseAddr    = 32'h0010_0000,
  parameter int          ReadLatency = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   ready_o,
  input  logic                   a_req_i,
  input  logic                   a_we_i,
  input  logic [DataWidth/8-1:0] a_be_i,
  input  logic [31:0]            a_addr_i,
  input  logic [DataWidth-1:0]   a_wdata_i,
  output logic                   a_rvalid_o,
  output logic [DataWidth-1:0]   a_rdata_o,
  output logic                   a_err_o,
  input  logic                   b_req_i,
  input  logic                   b_we_i,
  input  logic [DataWidth/8-1:0] b_be_i,
  input  logic [31:0]            b_addr_i,
  input  logic [DataWidth-1:0]   b_wdata_i,
  output logic                   b_rvalid_o,
  output logic [DataWidth-1:0]   b_rdata_o,
  output logic                   b_err_o
);

  localparam int          ByteW    = DataWidth / 8;
  localparam int          OffW     = $clog2(ByteW);
  localparam int          AddrW    = $clog2(Depth);
  localparam logic [32:0] MemBytes = 33'(Depth * ByteW);

  init_state_e      state_reg, state_next;
  logic [AddrW-1:0] cnt_reg, cnt_next;
  logic             init_we;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    init_we    = 1'b0;
    case (state_reg)
      INIT: begin
        init_we  = 1'b1;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == AddrW'(Depth - 1)) state_next = READY;
      end
      default: ;
    endcase
  end

  assign ready_o = (state_reg == READY);

  // Port 0 is A, port 1 is B throughout.
  logic [1:0]             req, we, acc, hit, wr;
  logic [2*ByteW-1:0]     be_flat;
  logic [63:0]            addr_flat;
  logic [2*DataWidth-1:0] wdata_flat, rdata_flat;
  logic [2*AddrW-1:0]     idx_flat;
  logic [1:0]             rvalid, err;

  assign req        = {b_req_i, a_req_i};
  assign we         = {b_we_i, a_we_i};
  assign be_flat    = {b_be_i, a_be_i};
  assign addr_flat  = {b_addr_i, a_addr_i};
  assign wdata_flat = {b_wdata_i, a_wdata_i};

  logic [DataWidth-1:0] mem [Depth];

  // Port B bytes are written first so port A overrides them on collisions.
  always_ff @(posedge clk_i) begin
    if (init_we) mem[cnt_reg] <= '0;
    for (int p = 1; p >= 0; p--) begin
      for (int k = 0; k < ByteW; k++) begin
        if (wr[p] && be_flat[p*ByteW+k])
          mem[idx_flat[p*AddrW +: AddrW]][8*k +: 8] <= wdata_flat[p*DataWidth+8*k +: 8];
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [DataWidth-1:0] rd_q;

    assign hit[gi] = in_range(addr_flat[32*gi +: 32], BaseAddr, MemBytes);
    assign acc[gi] = req[gi] & ready_o;
    assign wr[gi]  = acc[gi] & we[gi] & hit[gi];
    assign idx_flat[gi*AddrW +: AddrW] = AddrW'((addr_flat[32*gi +: 32] - BaseAddr) >> OffW);

    // Non-blocking read next to the write block gives read-first semantics.
    always_ff @(posedge clk_i) begin
      if (rst_i) rd_q <= '0;
      else if (acc[gi]) rd_q <= mem[idx_flat[gi*AddrW +: AddrW]];
    end

    dp_data_ram_resp_pipe #(
      .DataWidth  (DataWidth),
      .ReadLatency(ReadLatency)
    ) u_resp_pipe (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (acc[gi]),
      .err_i   (~hit[gi]),
      .rdata_i (rd_q),
      .rvalid_o(rvalid[gi]),
      .err_o   (err[gi]),
      .rdata_o (rdata_flat[gi*DataWidth +: DataWidth])
    );
  end

  assign a_rvalid_o = rvalid[0];
  assign a_err_o    = err[0];
  assign a_rdata_o  = rdata_flat[DataWidth-1:0];
  assign b_rvalid_o = rvalid[1];
  assign b_err_o    = err[1];
  assign b_rdata_o  = rdata_flat[2*DataWidth-1:DataWidth];

endmodule

// File: tb/tb_dp_data_ram.sv
// Directed bench for dp_data_ram: a one-cycle instance driven against a word
// model with a response scoreboard, plus a two-cycle instance for streaming/reset.
module tb_dp_data_ram;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t q2[$];

  logic [31:0] model [16];

  // Latency-1 instance
  logic        rst = 1'b1, ready;
  logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [3:0]  a_be = 0, b_be = 0;
  logic [31:0] a_addr = 0, b_addr = 0, a_wdata = 0, b_wdata = 0;
  logic        a_rvalid, b_rvalid, a_err, b_err;
  logic [31:0] a_rdata, b_rdata;

  // Latency-2 instance (port B idle)
  logic        rst2 = 1'b1, ready2;
  logic        a2_req = 0;
  logic [31:0] a2_addr = 0;
  logic        a2_rvalid, a2_err, b2_rvalid, b2_err;
  logic [31:0] a2_rdata, b2_rdata;

  dp_data_ram #(.Depth(16), .DataWidth(32), .BaseAddr(32'h1000), .ReadLatency(1)) dut (
    .clk_i(clk), .rst_i(rst), .ready_o(ready),
    .a_req_i(a_req), .a_we_i(a_we), .a_be_i(a_be), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata), .a_err_o(a_err),
    .b_req_i(b_req), .b_we_i(b_we), .b_be_i(b_be), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata), .b_err_o(b_err)
  );

  dp_data_ram #(.Depth(16), .DataWidth(32), .BaseAddr(32'h1000), .ReadLatency(2)) dut2 (
    .clk_i(clk), .rst_i(rst2), .ready_o(ready2),
    .a_req_i(a2_req), .a_we_i(1'b0), .a_be_i(4'h0), .a_addr_i(a2_addr), .a_wdata_i(32'h0),
    .a_rvalid_o(a2_rvalid), .a_rdata_o(a2_rdata), .a_err_o(a2_err),
    .b_req_i(1'b0), .b_we_i(1'b0), .b_be_i(4'h0), .b_addr_i(32'h0), .b_wdata_i(32'h0),
    .b_rvalid_o(b2_rvalid), .b_rdata_o(b2_rdata), .b_err_o(b2_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response scoreboards, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (a_rvalid === 1'b1) begin
      if (qa.size() == 0) chk("a_spurious_rvalid", 32'(a_rvalid), 32'd0);
      else begin
        e = qa.pop_front();
        $display("A rsp cyc=%0d rdata=%08h err=%0b", cyc, a_rdata, a_err);
        chk("a_rdata", a_rdata, e.rdata);
        chk("a_err", 32'(a_err), 32'(e.err));
        chk("a_latency", cyc, e.cyc);
      end
    end
    if (b_rvalid === 1'b1) begin
      if (qb.size() == 0) chk("b_spurious_rvalid", 32'(b_rvalid), 32'd0);
      else begin
        e = qb.pop_front();
        $display("B rsp cyc=%0d rdata=%08h err=%0b", cyc, b_rdata, b_err);
        chk("b_rdata", b_rdata, e.rdata);
        chk("b_err", 32'(b_err), 32'(e.err));
        chk("b_latency", cyc, e.cyc);
      end
    end
    if (a2_rvalid === 1'b1) begin
      if (q2.size() == 0) chk("a2_spurious_rvalid", 32'(a2_rvalid), 32'd0);
      else begin
        e = q2.pop_front();
        $display("A2 rsp cyc=%0d rdata=%08h err=%0b", cyc, a2_rdata, a2_err);
        chk("a2_rdata", a2_rdata, e.rdata);
        chk("a2_err", 32'(a2_err), 32'(e.err));
        chk("a2_latency", cyc, e.cyc);
      end
    end
    if (b2_rvalid === 1'b1) chk("b2_spurious_rvalid", 32'(b2_rvalid), 32'd0);
  end

  // Drives the current A/B request for one cycle; expectations come from the
  // model before any write of this cycle is applied (read-first).
  task automatic issue();
    exp_t ea, eb;
    logic ra, rb, acc_a, acc_b;
    int   ia, ib;
    ra = (a_addr >= 32'h1000) && (a_addr < 32'h1040);
    rb = (b_addr >= 32'h1000) && (b_addr < 32'h1040);
    ia = ra ? int'((a_addr - 32'h1000) >> 2) : 0;
    ib = rb ? int'((b_addr - 32'h1000) >> 2) : 0;
    acc_a = a_req && ready;
    acc_b = b_req && ready;
    if (acc_a) begin
      ea.rdata = ra ? model[ia] : 32'h0; ea.err = !ra; ea.cyc = cyc + 1;
      qa.push_back(ea);
    end
    if (acc_b) begin
      eb.rdata = rb ? model[ib] : 32'h0; eb.err = !rb; eb.cyc = cyc + 1;
      qb.push_back(eb);
    end
    for (int k = 0; k < 4; k++) begin
      if (acc_b && b_we && rb && b_be[k]) model[ib][8*k +: 8] = b_wdata[8*k +: 8];
    end
    for (int k = 0; k < 4; k++) begin
      if (acc_a && a_we && ra && a_be[k]) model[ia][8*k +: 8] = a_wdata[8*k +: 8];
    end
    @(posedge clk); #1;
    a_req = 0; b_req = 0;
  endtask

  task automatic set_a(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata);
    a_req = 1; a_we = we; a_be = be; a_addr = addr; a_wdata = wdata;
  endtask

  task automatic set_b(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata);
    b_req = 1; b_we = we; b_be = be; b_addr = addr; b_wdata = wdata;
  endtask

  task automatic issue2(input logic [31:0] addr);
    exp_t e;
    a2_req = 1; a2_addr = addr;
    if (ready2) begin
      e.rdata = 32'h0; e.err = 1'b0; e.cyc = cyc + 2;
      q2.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
    chk("queues_drained", 32'(qa.size() + qb.size() + q2.size()), 32'd0);
  endtask

  task automatic count_init(input bit second, output int n);
    n = 0;
    while (((second ? ready2 : ready) !== 1'b1) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;

    // Reset state
    rst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_b_rvalid", 32'(b_rvalid), 32'd0);
    chk("rst_a_rdata", a_rdata, 32'h0);
    chk("rst_b_err", 32'(b_err), 32'd0);

    // INIT length; writes offered during INIT must be dropped silently
    rst = 0;
    set_a(1'b1, 4'hF, 32'h1000, 32'hFFFF_FFFF);
    count_init(1'b0, n);
    a_req = 0;
    chk("init_cycles", n, 32'd16);

    // Test 1: read of last word after init
    set_b(1'b0, 4'h0, 32'h103C, 32'h0); issue();

    // Test 2: partial byte write then read on other port
    set_a(1'b1, 4'b0101, 32'h1004, 32'hAABB_CCDD); issue();
    set_b(1'b0, 4'h0, 32'h1004, 32'h0); issue();

    // Test 3: colliding writes, A wins overlapping bytes
    set_a(1'b1, 4'b0011, 32'h1008, 32'h1111_1111);
    set_b(1'b1, 4'b1110, 32'h1008, 32'h2222_2222); issue();
    set_a(1'b0, 4'h0, 32'h1008, 32'h0); issue();

    // Test 4: read-first across ports
    set_a(1'b1, 4'hF, 32'h100C, 32'h0000_0005);
    set_b(1'b0, 4'h0, 32'h100C, 32'h0); issue();
    set_b(1'b0, 4'h0, 32'h100C, 32'h0); issue();
    drain();

    // Test 5: out-of-range read and write, then full scan on both ports
    set_b(1'b0, 4'h0, 32'h1040, 32'h0); issue();
    set_a(1'b1, 4'hF, 32'h0FFC, 32'hDEAD_BEEF); issue();
    for (int i = 0; i < 16; i++) begin
      set_a(1'b0, 4'h0, 32'h1000 + 32'(4 * i), 32'h0);
      set_b(1'b0, 4'h0, 32'h1000 + 32'(4 * (15 - i)), 32'h0);
      issue();
    end
    drain();

    // Test 6: two-cycle latency instance
    rst2 = 1;
    @(posedge clk); #1;
    rst2 = 0;
    count_init(1'b1, n);
    chk("init2_cycles", n, 32'd16);
    for (int i = 0; i < 4; i++) issue2(32'h1000 + 32'(4 * i));
    a2_req = 0;
    drain();

    issue2(32'h1000);
    issue2(32'h1004);
    a2_req = 0;
    rst2 = 1;
    @(posedge clk); #1;
    q2.delete();
    rst2 = 0;
    chk("rst2_rvalid", 32'(a2_rvalid), 32'd0);
    count_init(1'b1, n);
    chk("reinit2_cycles", n, 32'd16);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
